// File: rtl/stream_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_accumulator_if
// Description : Sample-in / result-out stream bundle for stream_accumulator.
//               The input side is a valid/ready sample stream. The output side
//               is a valid/ready result stream carrying the frame sum, the
//               overflow flag and a debug count of accepted samples.
//               slave  : the accumulator itself
//               master : the producer/consumer that surrounds it
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 32,
    parameter int CNT_W  = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic              out_overflow;
    logic [CNT_W-1:0]  out_count;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_sum,
        output out_overflow,
        output out_count
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  out_overflow,
        input  out_count
    );
endinterface
`default_nettype wire

// File: rtl/stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : stream_accumulator
// Description : Sums a frame of LEN samples into one SUM_W-bit result, with
//               selectable signedness and wrap/saturate behaviour, and hands
//               the result out on a valid/ready stream with a sticky overflow
//               flag.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - stream_accumulator_if.slave
//                       in_valid/in_ready/in_data   : sample stream
//                       out_valid/out_ready         : result handshake
//                       out_sum/out_overflow        : frame result
//                       out_count                   : samples taken this frame
// Parameters  : DATA_W >= 1, SUM_W >= DATA_W, LEN >= 1, SIGNED, SATURATE
// Revision    : 1.0 - initial release
// ============================================================================
module stream_accumulator #(
    parameter int DATA_W   = 8,
    parameter int SUM_W    = 32,
    parameter int LEN      = 500,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    stream_accumulator_if.slave bus
);
    localparam int               CNT_W  = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LEN - 1);
    localparam logic [SUM_W-1:0] C_UMAX = '1;
    localparam logic [SUM_W-1:0] C_SMAX = C_UMAX >> 1;
    localparam logic [SUM_W-1:0] C_SMIN = ~C_SMAX;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [SUM_W-1:0] r_acc;
    logic [SUM_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_count;
    logic             r_sticky;
    logic             r_out_valid;
    logic             r_out_overflow;

    logic [SUM_W-1:0] w_ext;
    logic [SUM_W-1:0] w_add;
    logic [SUM_W-1:0] w_acc_next;
    logic             w_ovf;
    logic             w_sticky_next;
    logic             w_in_ready;
    logic             w_beat;
    logic             w_last;
    logic             w_release;

    // ------------------------------------------------------------------
    // Sample extension and the single adder with its overflow detect
    // ------------------------------------------------------------------
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_ext = SUM_W'($signed(bus.in_data));
            assign w_add = r_acc + w_ext;
            // Two same-signed operands producing the other sign.
            assign w_ovf = (r_acc[SUM_W-1] == w_ext[SUM_W-1]) &&
                           (w_add[SUM_W-1] != r_acc[SUM_W-1]);
        end else begin : g_unsigned
            logic w_carry;
            assign w_ext = SUM_W'(bus.in_data);
            assign {w_carry, w_add} = {1'b0, r_acc} + {1'b0, w_ext};
            assign w_ovf = w_carry;
        end
    endgenerate

    generate
        if (SATURATE != 0) begin : g_saturate
            // Signed overflow can only happen with both operands of the same
            // sign, so the accumulator's sign gives the clamp direction.
            logic [SUM_W-1:0] w_sat_val;
            assign w_sat_val  = (SIGNED != 0) ? (r_acc[SUM_W-1] ? C_SMIN : C_SMAX)
                                              : C_UMAX;
            assign w_acc_next = w_ovf ? w_sat_val : w_add;
        end else begin : g_wrap
            assign w_acc_next = w_add;
        end
    endgenerate

    assign w_sticky_next = r_sticky | w_ovf;

    // ------------------------------------------------------------------
    // Control FSM: in_ready depends on state only, and out_valid is a
    // register, so neither handshake has a combinational loop-back.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_beat       = 1'b0;
        w_last       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_in_ready = 1'b1;
                w_beat     = bus.in_valid;
                w_last     = bus.in_valid && (r_count == C_LAST);
                if (w_last) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_release = r_out_valid && bus.out_ready;
                if (w_release) begin
                    w_state_next = ST_ACC;
                end
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath. out_sum/out_overflow are only written on the closing beat,
    // so they stay stable throughout HOLD and after the handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc          <= '0;
            r_count        <= '0;
            r_sticky       <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_sum      <= '0;
            r_out_overflow <= 1'b0;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_sticky    <= 1'b0;
        end else if (w_beat) begin
            r_acc    <= w_acc_next;
            r_count  <= r_count + CNT_W'(1);
            r_sticky <= w_sticky_next;
            if (w_last) begin
                r_out_sum      <= w_acc_next;
                r_out_overflow <= w_sticky_next;
                r_out_valid    <= 1'b1;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_sum      = r_out_sum;
    assign bus.out_overflow = r_out_overflow;
    assign bus.out_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_accumulator
// Description : Directed bench for stream_accumulator. Five instances cover
//               the default configuration, 8-bit unsigned wrap and saturate,
//               signed 32-bit, and signed 8-bit saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_accumulator;
    localparam int C_CW0 = $clog2(500 + 1);
    localparam int C_CW2 = $clog2(2 + 1);
    localparam int C_CW4 = $clog2(4 + 1);

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    stream_accumulator_if #(.DATA_W(8), .SUM_W(32), .CNT_W(C_CW0)) bus0 ();
    stream_accumulator_if #(.DATA_W(8), .SUM_W(8),  .CNT_W(C_CW2)) bus1 ();
    stream_accumulator_if #(.DATA_W(8), .SUM_W(8),  .CNT_W(C_CW2)) bus2 ();
    stream_accumulator_if #(.DATA_W(8), .SUM_W(32), .CNT_W(C_CW4)) bus3 ();
    stream_accumulator_if #(.DATA_W(8), .SUM_W(8),  .CNT_W(C_CW2)) bus4 ();

    stream_accumulator u_def (.clk(clk), .rst_n(rst_n), .bus(bus0));
    stream_accumulator #(.DATA_W(8), .SUM_W(8), .LEN(2), .SIGNED(0), .SATURATE(0))
        u_wrap (.clk(clk), .rst_n(rst_n), .bus(bus1));
    stream_accumulator #(.DATA_W(8), .SUM_W(8), .LEN(2), .SIGNED(0), .SATURATE(1))
        u_usat (.clk(clk), .rst_n(rst_n), .bus(bus2));
    stream_accumulator #(.DATA_W(8), .SUM_W(32), .LEN(4), .SIGNED(1), .SATURATE(0))
        u_sgn (.clk(clk), .rst_n(rst_n), .bus(bus3));
    stream_accumulator #(.DATA_W(8), .SUM_W(8), .LEN(2), .SIGNED(1), .SATURATE(1))
        u_ssat (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if (bus0.in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", bus0.in_ready); fails++;
        end
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b expected 0", bus0.out_valid); fails++;
        end
        checks++;
        if (bus0.out_sum !== 32'd0 || bus0.out_overflow !== 1'b0) begin
            $display("FAIL reset_result: got sum %0d ovf %b expected 0/0",
                     bus0.out_sum, bus0.out_overflow); fails++;
        end
        checks++;
        if (bus0.out_count !== 9'd0) begin
            $display("FAIL reset_count: got %0d expected 0", bus0.out_count); fails++;
        end
        checks++;
    endtask

    task automatic test_basic();
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 8'd10;
            if (i == 499) begin
                if (bus0.out_valid !== 1'b0 || bus0.out_count !== 9'd499) begin
                    $display("FAIL basic_pre_last: got valid %b count %0d expected 0/499",
                             bus0.out_valid, bus0.out_count); fails++;
                end
                checks++;
            end
            tick();
        end
        bus0.in_valid = 1'b0;
        if (bus0.out_valid !== 1'b1 || bus0.out_sum !== 32'd5000 || bus0.out_overflow !== 1'b0) begin
            $display("FAIL basic_result: got valid %b sum %0d ovf %b expected 1/5000/0",
                     bus0.out_valid, bus0.out_sum, bus0.out_overflow); fails++;
        end
        checks++;
        if (bus0.in_ready !== 1'b0 || bus0.out_count !== 9'd500) begin
            $display("FAIL basic_hold: got in_ready %b count %0d expected 0/500",
                     bus0.in_ready, bus0.out_count); fails++;
        end
        checks++;
        tick();
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.out_count !== 9'd0) begin
            $display("FAIL basic_release: got in_ready %b valid %b count %0d expected 1/0/0",
                     bus0.in_ready, bus0.out_valid, bus0.out_count); fails++;
        end
        checks++;
    endtask

    task automatic test_gaps();
        int  ref_sum;
        int  ref_cnt;
        int  cyc;
        int  d;
        logic v;
        ref_sum = 0;
        ref_cnt = 0;
        cyc     = 0;
        bus0.out_ready = 1'b1;
        while (ref_cnt < 500 && cyc < 5000) begin
            if (bus0.out_count !== ref_cnt[8:0]) begin
                $display("FAIL gaps_count: got %0d expected %0d", bus0.out_count, ref_cnt); fails++;
            end
            checks++;
            v = 1'($urandom_range(0, 1));
            d = int'($urandom_range(0, 10));
            bus0.in_valid = v;
            bus0.in_data  = d[7:0];
            tick();
            if (v) begin
                ref_cnt++;
                ref_sum += d;
            end
            cyc++;
        end
        bus0.in_valid = 1'b0;
        if (ref_cnt < 500) begin
            $display("FAIL gaps_timeout: got %0d beats expected 500", ref_cnt); fails++;
        end
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_sum !== 32'(ref_sum) || bus0.out_overflow !== 1'b0) begin
            $display("FAIL gaps_result: got valid %b sum %0d ovf %b expected 1/%0d/0",
                     bus0.out_valid, bus0.out_sum, bus0.out_overflow, ref_sum); fails++;
        end
        checks++;
        tick();
    endtask

    task automatic test_wrap_saturate();
        bus1.out_ready = 1'b1;
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus1.in_valid = 1'b1; bus1.in_data = 8'd255;
            bus2.in_valid = 1'b1; bus2.in_data = 8'd255;
            tick();
        end
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        if (bus1.out_valid !== 1'b1 || bus1.out_sum !== 8'd254 || bus1.out_overflow !== 1'b1) begin
            $display("FAIL wrap_result: got valid %b sum %0d ovf %b expected 1/254/1",
                     bus1.out_valid, bus1.out_sum, bus1.out_overflow); fails++;
        end
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_sum !== 8'd255 || bus2.out_overflow !== 1'b1) begin
            $display("FAIL usat_result: got valid %b sum %0d ovf %b expected 1/255/1",
                     bus2.out_valid, bus2.out_sum, bus2.out_overflow); fails++;
        end
        checks++;
        tick();
    endtask

    task automatic test_signed();
        bus3.out_ready = 1'b1;
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus3.in_valid = 1'b1; bus3.in_data = 8'hFF;
            bus4.in_valid = (i < 2); bus4.in_data = 8'h7F;
            tick();
            if (i == 1) begin
                bus4.in_valid = 1'b0;
                if (bus4.out_valid !== 1'b1 || bus4.out_sum !== 8'h7F || bus4.out_overflow !== 1'b1) begin
                    $display("FAIL ssat_result: got valid %b sum %h ovf %b expected 1/7f/1",
                             bus4.out_valid, bus4.out_sum, bus4.out_overflow); fails++;
                end
                checks++;
            end
        end
        bus3.in_valid = 1'b0;
        if (bus3.out_valid !== 1'b1 || bus3.out_sum !== 32'hFFFF_FFFC || bus3.out_overflow !== 1'b0) begin
            $display("FAIL signed_result: got valid %b sum %h ovf %b expected 1/fffffffc/0",
                     bus3.out_valid, bus3.out_sum, bus3.out_overflow); fails++;
        end
        checks++;
        tick();
    endtask

    task automatic test_backpressure();
        bus1.out_ready = 1'b0;
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 8'd3;
        tick();
        bus1.in_data   = 8'd4;
        tick();
        bus1.in_data   = 8'd100;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b1 ||
                bus1.out_sum !== 8'd7 || bus1.out_count !== 2'd2) begin
                $display("FAIL bp_hold: cycle %0d got ready %b valid %b sum %0d count %0d expected 0/1/7/2",
                         i, bus1.in_ready, bus1.out_valid, bus1.out_sum, bus1.out_count); fails++;
            end
            checks++;
        end
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.out_count !== 2'd0) begin
            $display("FAIL bp_release: got ready %b valid %b count %0d expected 1/0/0",
                     bus1.in_ready, bus1.out_valid, bus1.out_count); fails++;
        end
        checks++;
        tick();
        tick();
        bus1.in_valid = 1'b0;
        if (bus1.out_valid !== 1'b1 || bus1.out_sum !== 8'd200 || bus1.out_overflow !== 1'b0) begin
            $display("FAIL bp_next_frame: got valid %b sum %0d ovf %b expected 1/200/0",
                     bus1.out_valid, bus1.out_sum, bus1.out_overflow); fails++;
        end
        checks++;
        bus1.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 8'd1;
            tick();
        end
        bus0.in_valid = 1'b0;
        if (bus0.out_count !== 9'd100) begin
            $display("FAIL mid_count: got %0d expected 100", bus0.out_count); fails++;
        end
        checks++;
        rst_n = 1'b0;
        #2;
        if (bus0.out_count !== 9'd0 || bus0.out_sum !== 32'd0 ||
            bus0.out_valid !== 1'b0 || bus0.out_overflow !== 1'b0) begin
            $display("FAIL mid_async_clear: got count %0d sum %0d valid %b ovf %b expected 0/0/0/0",
                     bus0.out_count, bus0.out_sum, bus0.out_valid, bus0.out_overflow); fails++;
        end
        checks++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 8'd1;
            tick();
        end
        bus0.in_valid = 1'b0;
        if (bus0.out_valid !== 1'b1 || bus0.out_sum !== 32'd500 || bus0.out_overflow !== 1'b0) begin
            $display("FAIL mid_fresh_frame: got valid %b sum %0d ovf %b expected 1/500/0",
                     bus0.out_valid, bus0.out_sum, bus0.out_overflow); fails++;
        end
        checks++;
        tick();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        test_reset();
        test_basic();
        test_gaps();
        test_wrap_saturate();
        test_signed();
        test_backpressure();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
